// File: rtl/ddr_burst_master_if.sv
// AXI4 write/read burst channels between ddr_burst_master and the DDR3 AXI-to-MIG bridge.
// The bridge has no B channel and no rlast consumer, so neither appears here.
interface ddr_burst_master_if #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 256
) ();
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awlen, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    output araddr, arlen, arvalid, input arready,
    input  rdata, rvalid, output rready
  );

  modport slave (
    input  awaddr, awlen, awvalid, output awready,
    input  wdata, wstrb, wlast, wvalid, output wready,
    input  araddr, arlen, arvalid, output arready,
    output rdata, rvalid, input rready
  );
endinterface

// File: rtl/ddr_burst_master.sv
// Single-outstanding AXI4 burst master feeding the DDR3 AXI-to-MIG bridge, with a read FIFO.
// Optional performance counters are enabled by defining DDR_BM_PERF_EN.
module ddr_burst_master #(
  parameter int ADDR_W        = 30,
  parameter int DATA_W        = 256,
  parameter int MAX_LEN       = 16,
  parameter int RD_FIFO_DEPTH = 32
) (
  input  logic              ui_clk,
  input  logic              ui_clk_sync_rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [7:0]        cmd_len,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              busy,
  output logic              err_len,
  output logic              err_rd_ovf,
`ifdef DDR_BM_PERF_EN
  output logic [31:0]       perf_wr_beats,
  output logic [31:0]       perf_rd_beats,
  output logic [31:0]       perf_stall,
`endif
  ddr_burst_master_if.master m_axi
);

  localparam int PTR_W = $clog2(RD_FIFO_DEPTH);
  localparam logic [7:0]  LEN_MAX = 8'(MAX_LEN - 1);
  localparam logic [15:0] DEPTH16 = 16'(RD_FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_AR_WAIT, S_AR, S_R} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        len_q, len_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              err_len_q, err_len_d;
  logic              err_ovf_q, err_ovf_d;

  logic [PTR_W:0]    wptr_q, rptr_q;
  logic [PTR_W:0]    fifo_cnt;
  logic [DATA_W-1:0] mem_data_q [RD_FIFO_DEPTH];
  logic [RD_FIFO_DEPTH-1:0] mem_last_q;
  logic              fifo_full, fifo_empty, push, pop;
  logic [15:0]       credit_need;
  logic              beat_is_last;
  logic              unused_addr_lsbs;

  assign unused_addr_lsbs = ^cmd_addr[4:0];

  assign fifo_cnt   = wptr_q - rptr_q;
  assign fifo_empty = (wptr_q == rptr_q);
  assign fifo_full  = (wptr_q[PTR_W] != rptr_q[PTR_W]) &&
                      (wptr_q[PTR_W-1:0] == rptr_q[PTR_W-1:0]);
  assign pop        = rd_ready && !fifo_empty;
  // A full FIFO can still take a beat when the sink frees a slot in the same cycle.
  assign push       = (state_q == S_R) && m_axi.rvalid && (!fifo_full || pop);
  assign beat_is_last = (cnt_q == len_q);
  assign credit_need  = 16'(fifo_cnt) - 16'(pop) + 16'(len_q) + 16'd1;

  assign cmd_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign err_len    = err_len_q;
  assign err_rd_ovf = err_ovf_q;
  assign rd_valid   = !fifo_empty;
  assign rd_data    = mem_data_q[rptr_q[PTR_W-1:0]];
  assign rd_last    = !fifo_empty && mem_last_q[rptr_q[PTR_W-1:0]];
  assign wr_ready   = (state_q == S_W) && m_axi.wready;

  assign m_axi.awaddr  = addr_q;
  assign m_axi.awlen   = len_q;
  assign m_axi.awvalid = (state_q == S_AW);
  assign m_axi.wdata   = wr_data;
  assign m_axi.wstrb   = '1;
  assign m_axi.wlast   = (state_q == S_W) && beat_is_last;
  assign m_axi.wvalid  = (state_q == S_W) && wr_valid;
  assign m_axi.araddr  = addr_q;
  assign m_axi.arlen   = len_q;
  assign m_axi.arvalid = (state_q == S_AR);
  // The bridge gates arready on rready, so this doubles as read back-pressure.
  assign m_axi.rready  = !fifo_full;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    err_len_d = err_len_q;
    err_ovf_d = err_ovf_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          addr_d = {cmd_addr[ADDR_W-1:5], 5'b0};
          len_d  = cmd_len;
          cnt_d  = 8'd0;
          if (cmd_len > LEN_MAX) err_len_d = 1'b1;
          else if (cmd_write)    state_d = S_AW;
          else                   state_d = S_AR_WAIT;
        end
      end
      S_AW: if (m_axi.awready) state_d = S_W;
      S_W: begin
        if (wr_valid && m_axi.wready) begin
          if (beat_is_last) begin
            cnt_d   = 8'd0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      S_AR_WAIT: if (credit_need <= DEPTH16) state_d = S_AR;
      S_AR: if (m_axi.arready) state_d = S_R;
      S_R: begin
        if (m_axi.rvalid) begin
          if (fifo_full && !pop) err_ovf_d = 1'b1;
          if (beat_is_last) begin
            cnt_d   = 8'd0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ui_clk) begin
    if (ui_clk_sync_rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 8'd0;
      err_len_q <= 1'b0;
      err_ovf_q <= 1'b0;
      wptr_q    <= '0;
      rptr_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      err_len_q <= err_len_d;
      err_ovf_q <= err_ovf_d;
      wptr_q    <= wptr_q + {{PTR_W{1'b0}}, push};
      rptr_q    <= rptr_q + {{PTR_W{1'b0}}, pop};
    end
  end

  // Command fields and FIFO storage carry no reset; validity comes from state and pointers.
  always_ff @(posedge ui_clk) begin
    addr_q <= addr_d;
    len_q  <= len_d;
    if (push) begin
      mem_data_q[wptr_q[PTR_W-1:0]] <= m_axi.rdata;
      mem_last_q[wptr_q[PTR_W-1:0]] <= beat_is_last;
    end
  end

`ifdef DDR_BM_PERF_EN
  logic [31:0] perf_wr_q, perf_rd_q, perf_stall_q;
  logic        stall_cyc;

  assign stall_cyc = (state_q == S_AR_WAIT) ||
                     ((state_q == S_AW) && !m_axi.awready) ||
                     ((state_q == S_AR) && !m_axi.arready);

  always_ff @(posedge ui_clk) begin
    if (ui_clk_sync_rst) begin
      perf_wr_q    <= 32'd0;
      perf_rd_q    <= 32'd0;
      perf_stall_q <= 32'd0;
    end else begin
      if (m_axi.wvalid && m_axi.wready) perf_wr_q <= perf_wr_q + 32'd1;
      if (push)                         perf_rd_q <= perf_rd_q + 32'd1;
      if (stall_cyc)                    perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_wr_beats = perf_wr_q;
  assign perf_rd_beats = perf_rd_q;
  assign perf_stall    = perf_stall_q;
`endif

endmodule

// File: tb/tb_ddr_burst_master.sv
// Directed bench for ddr_burst_master: the bench plays the bridge by hand and checks
// every expectation with an immediate assertion.
module tb_ddr_burst_master;
  localparam int ADDR_W = 30;
  localparam int DATA_W = 256;

  logic              ui_clk;
  logic              ui_clk_sync_rst;
  logic              cmd_valid, cmd_ready, cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [7:0]        cmd_len;
  logic [DATA_W-1:0] wr_data;
  logic              wr_valid, wr_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_last, rd_valid, rd_ready;
  logic              busy, err_len, err_rd_ovf;

  int tests = 0;
  int fails = 0;

  ddr_burst_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m_axi ();

  ddr_burst_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_LEN(16), .RD_FIFO_DEPTH(32)) dut (
    .ui_clk(ui_clk), .ui_clk_sync_rst(ui_clk_sync_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_last(rd_last), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .busy(busy), .err_len(err_len), .err_rd_ovf(err_rd_ovf),
    .m_axi(m_axi)
  );

  initial ui_clk = 1'b0;
  always #5 ui_clk = ~ui_clk;

  task automatic tick();
    @(posedge ui_clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic chkv(input string tag, input logic [255:0] got, input logic [255:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] wbeat(input int n);
    return {8{32'hA500_0000 + 32'(n)}};
  endfunction

  function automatic logic [255:0] rbeat(input int n);
    return {8{32'hD000_0000 + 32'(n)}};
  endfunction

  task automatic issue(input logic wr, input logic [ADDR_W-1:0] a, input logic [7:0] l);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_len   = l;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic rd_burst(input logic [ADDR_W-1:0] a, input int len, input int base);
    issue(1'b0, a, 8'(len));
    for (int k = 0; k < 20 && !m_axi.arvalid; k++) tick();
    chk1("ar_issue", m_axi.arvalid, 1'b1);
    chkv("araddr", 256'(m_axi.araddr), 256'(a));
    m_axi.arready = 1'b1;
    tick();
    m_axi.arready = 1'b0;
    for (int i = 0; i <= len; i++) begin
      m_axi.rvalid = 1'b1;
      m_axi.rdata  = rbeat(base + i);
      tick();
    end
    m_axi.rvalid = 1'b0;
  endtask

  initial begin
    int n;
    int lasts;
    ui_clk_sync_rst = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_data = '0; wr_valid = 1'b0; rd_ready = 1'b0;
    m_axi.awready = 1'b0; m_axi.wready = 1'b0; m_axi.arready = 1'b0;
    m_axi.rdata = '0; m_axi.rvalid = 1'b0;
    repeat (3) tick();
    ui_clk_sync_rst = 1'b0;
    tick();

    // Reset state
    chk1("rst_cmd_ready", cmd_ready, 1'b1);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_rd_valid", rd_valid, 1'b0);
    chk1("rst_rd_last", rd_last, 1'b0);
    chk1("rst_err_len", err_len, 1'b0);
    chk1("rst_err_ovf", err_rd_ovf, 1'b0);
    chk1("rst_awvalid", m_axi.awvalid, 1'b0);
    chk1("rst_arvalid", m_axi.arvalid, 1'b0);
    chk1("rst_wvalid", m_axi.wvalid, 1'b0);
    chk1("rst_wlast", m_axi.wlast, 1'b0);
    chk1("rst_rready", m_axi.rready, 1'b1);

    // Four-beat write at 0x100 with wready held high
    issue(1'b1, 30'h100, 8'd3);
    chk1("w_awvalid", m_axi.awvalid, 1'b1);
    chkv("w_awaddr", 256'(m_axi.awaddr), 256'h100);
    chkv("w_awlen", 256'(m_axi.awlen), 256'd3);
    chk1("w_cmd_ready_busy", cmd_ready, 1'b0);
    chk1("w_wr_ready_aw", wr_ready, 1'b0);
    m_axi.awready = 1'b1;
    tick();
    m_axi.awready = 1'b0;
    chk1("w_awvalid_drop", m_axi.awvalid, 1'b0);
    m_axi.wready = 1'b1;
    wr_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_data = wbeat(i);
      #1;
      chk1("w_wvalid", m_axi.wvalid, 1'b1);
      chkv("w_wdata", m_axi.wdata, wbeat(i));
      chk1("w_wlast", m_axi.wlast, (i == 3));
      chkv("w_wstrb", 256'(m_axi.wstrb), 256'hFFFF_FFFF);
      chk1("w_wr_ready", wr_ready, 1'b1);
      tick();
    end
    chk1("w_done_cmd_ready", cmd_ready, 1'b1);
    chk1("w_done_busy", busy, 1'b0);
    chk1("w_done_wvalid", m_axi.wvalid, 1'b0);
    wr_valid = 1'b0;
    m_axi.wready = 1'b0;

    // Sixteen-beat read at 0x2000 into an empty FIFO, sink always ready
    rd_ready = 1'b1;
    issue(1'b0, 30'h2000, 8'd15);
    chk1("r_wait_arvalid", m_axi.arvalid, 1'b0);
    chk1("r_wait_busy", busy, 1'b1);
    tick();
    chk1("r_arvalid", m_axi.arvalid, 1'b1);
    chkv("r_araddr", 256'(m_axi.araddr), 256'h2000);
    chkv("r_arlen", 256'(m_axi.arlen), 256'd15);
    m_axi.arready = 1'b1;
    tick();
    m_axi.arready = 1'b0;
    chk1("r_arvalid_drop", m_axi.arvalid, 1'b0);
    for (int i = 0; i < 16; i++) begin
      m_axi.rvalid = 1'b1;
      m_axi.rdata  = rbeat(i);
      tick();
      chk1("r_rd_valid", rd_valid, 1'b1);
      chkv("r_rd_data", rd_data, rbeat(i));
      chk1("r_rd_last", rd_last, (i == 15));
      chk1("r_busy", busy, (i != 15));
    end
    m_axi.rvalid = 1'b0;
    tick();
    chk1("r_drained", rd_valid, 1'b0);
    rd_ready = 1'b0;

    // Credit stall: 20 unpopped beats, then a 16-beat read must wait for 4 pops
    rd_burst(30'h3000, 15, 32'h100);
    rd_burst(30'h3200, 3, 32'h200);
    chkv("c_head", rd_data, rbeat(32'h100));
    chk1("c_head_last", rd_last, 1'b0);
    issue(1'b0, 30'h3400, 8'd15);
    for (int k = 0; k < 3; k++) begin
      chk1("c_stall_arvalid", m_axi.arvalid, 1'b0);
      tick();
    end
    rd_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk1("c_pop_arvalid", m_axi.arvalid, 1'b0);
    end
    tick();
    rd_ready = 1'b0;
    chk1("c_release_arvalid", m_axi.arvalid, 1'b1);
    chkv("c_head_after_pops", rd_data, rbeat(32'h104));
    m_axi.arready = 1'b1;
    tick();
    m_axi.arready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      m_axi.rvalid = 1'b1;
      m_axi.rdata  = rbeat(32'h300 + i);
      tick();
    end
    m_axi.rvalid = 1'b0;
    chk1("c_full_rready", m_axi.rready, 1'b0);
    chk1("c_no_ovf", err_rd_ovf, 1'b0);
    rd_ready = 1'b1;
    n = 0;
    lasts = 0;
    for (int k = 0; k < 40; k++) begin
      if (rd_valid) begin
        n++;
        if (rd_last) lasts++;
      end
      tick();
    end
    rd_ready = 1'b0;
    chkv("c_drain_count", 256'(n), 256'd32);
    chkv("c_drain_lasts", 256'(lasts), 256'd3);
    chk1("c_drain_empty", rd_valid, 1'b0);
    chk1("c_drain_rready", m_axi.rready, 1'b1);

    // Illegal length is flagged and produces no AXI traffic
    issue(1'b1, 30'h500, 8'd16);
    chk1("e_err_len", err_len, 1'b1);
    chk1("e_cmd_ready", cmd_ready, 1'b1);
    for (int k = 0; k < 3; k++) begin
      chk1("e_awvalid", m_axi.awvalid, 1'b0);
      chk1("e_arvalid", m_axi.arvalid, 1'b0);
      tick();
    end
    chk1("e_err_len_sticky", err_len, 1'b1);

    // Unaligned address with wready stalls
    issue(1'b1, 30'h1F3, 8'd1);
    chkv("a_awaddr", 256'(m_axi.awaddr), 256'h1E0);
    chkv("a_awlen", 256'(m_axi.awlen), 256'd1);
    m_axi.awready = 1'b1;
    tick();
    m_axi.awready = 1'b0;
    wr_valid = 1'b1;
    wr_data  = wbeat(32'h50);
    #1;
    chk1("a_wr_ready_stall", wr_ready, 1'b0);
    chk1("a_wlast0", m_axi.wlast, 1'b0);
    tick();
    chkv("a_wdata_held", m_axi.wdata, wbeat(32'h50));
    chk1("a_wlast0_held", m_axi.wlast, 1'b0);
    m_axi.wready = 1'b1;
    #1;
    chk1("a_wr_ready", wr_ready, 1'b1);
    tick();
    m_axi.wready = 1'b0;
    wr_data = wbeat(32'h51);
    #1;
    chk1("a_wlast1", m_axi.wlast, 1'b1);
    tick();
    chk1("a_busy_stall", busy, 1'b1);
    chkv("a_wdata1_held", m_axi.wdata, wbeat(32'h51));
    m_axi.wready = 1'b1;
    tick();
    chk1("a_done_busy", busy, 1'b0);
    chk1("a_done_wvalid", m_axi.wvalid, 1'b0);
    chk1("a_done_wr_ready", wr_ready, 1'b0);
    wr_valid = 1'b0;
    m_axi.wready = 1'b0;

    // Single-beat read leaves one rd_last beat in the FIFO
    rd_burst(30'h40, 0, 32'h400);
    chk1("z_rd_valid", rd_valid, 1'b1);
    chk1("z_rd_last", rd_last, 1'b1);
    chkv("z_rd_data", rd_data, rbeat(32'h400));

    // Reset during beat 2 of a 4-beat write
    issue(1'b1, 30'h400, 8'd3);
    m_axi.awready = 1'b1;
    tick();
    m_axi.awready = 1'b0;
    m_axi.wready = 1'b1;
    wr_valid = 1'b1;
    wr_data  = wbeat(0);
    tick();
    wr_data = wbeat(1);
    #1;
    chk1("x_wvalid_before", m_axi.wvalid, 1'b1);
    ui_clk_sync_rst = 1'b1;
    tick();
    ui_clk_sync_rst = 1'b0;
    chk1("x_awvalid", m_axi.awvalid, 1'b0);
    chk1("x_wvalid", m_axi.wvalid, 1'b0);
    chk1("x_arvalid", m_axi.arvalid, 1'b0);
    chk1("x_rd_valid", rd_valid, 1'b0);
    chk1("x_rd_last", rd_last, 1'b0);
    chk1("x_busy", busy, 1'b0);
    chk1("x_err_len", err_len, 1'b0);
    chk1("x_err_ovf", err_rd_ovf, 1'b0);
    chk1("x_cmd_ready", cmd_ready, 1'b1);
    wr_valid = 1'b0;
    m_axi.wready = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ddr_burst_master.md
Name: ddr_burst_master

Overview:
AXI4 burst master that sits directly upstream of the DDR3 AXI-to-MIG bridge on the ui_clk domain. It turns simple host commands (write or read, 32-byte-aligned address, beat count) plus a write-data stream into single-outstanding AW/W and AR bursts. It returns read data through an internal FIFO. The bridge has no B response and its R channel ignores rready, so this block reserves FIFO space before issuing AR, and treats a write as complete when its last W beat is accepted.

Parameters:
ADDR_W, 30, byte address width; matches bridge awaddr/araddr.
DATA_W, 256, beat width; 32 bytes per beat.
MAX_LEN, 16, max beats per burst; legal cmd_len range is 0..MAX_LEN-1.
RD_FIFO_DEPTH, 32, read FIFO entries; power of 2, must be >= MAX_LEN.

Ports:
ui_clk  in  1  clock; all logic rising-edge.
ui_clk_sync_rst  in  1  reset, synchronous, active-high.
cmd_valid  in  1  command request.
cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready.
cmd_write  in  1  1=write, 0=read.
cmd_addr  in  ADDR_W  byte address; bits [4:0] ignored.
cmd_len  in  8  beats-1.
wr_data  in  DATA_W  write beat.
wr_valid  in  1  write beat valid.
wr_ready  out  1  write beat accepted.
rd_data  out  DATA_W  read beat from FIFO head.
rd_last  out  1  final beat of its burst.
rd_valid  out  1  FIFO non-empty.
rd_ready  in  1  sink pops head.
busy  out  1  state!=IDLE.
err_len  out  1  sticky: illegal cmd_len seen.
err_rd_ovf  out  1  sticky: R beat arrived with FIFO full.
m_axi_awaddr  out  ADDR_W.  m_axi_awlen  out  8.  m_axi_awvalid  out  1.  m_axi_awready  in  1.
m_axi_wdata  out  DATA_W.  m_axi_wstrb  out  DATA_W/8.  m_axi_wlast  out  1.  m_axi_wvalid  out  1.  m_axi_wready  in  1.
m_axi_araddr  out  ADDR_W.  m_axi_arlen  out  8.  m_axi_arvalid  out  1.  m_axi_arready  in  1.
m_axi_rdata  in  DATA_W.  m_axi_rvalid  in  1.  m_axi_rready  out  1.

Behaviour:
- Clocking and reset: single clock ui_clk; reset ui_clk_sync_rst is synchronous, active-high.
- Reset: state=IDLE, all *valid=0, wlast=0, FIFO flushed (rd_valid=0, rd_last=0), err_* = 0, counters=0. cmd_ready=1 the cycle after reset deasserts.
- Reset mid-burst: abandon the burst immediately. No attempt to finish AXI traffic.
- States: IDLE, AW, W, AR_WAIT, AR, R. cmd_ready = (state==IDLE).
- Accept in IDLE:
  - Latch addr as {cmd_addr[ADDR_W-1:5],5'b0} and latch len.
  - If cmd_len > MAX_LEN-1: set err_len, stay in IDLE, no AXI traffic.
  - Else write -> AW; read -> AR_WAIT.
- AW: awvalid=1, holding awaddr/awlen stable until awready, then -> W. The bridge does not assert wready before AW is accepted.
- W:
  - wvalid = wr_valid, wr_ready = wready, wdata = wr_data, wstrb = all ones.
  - beat counter increments on wvalid&&wready.
  - wlast = (cnt==len).
  - The last beat handshake -> IDLE next cycle, cnt=0.
  - wr_ready=0 in every other state.
- AR_WAIT: stay until fifo_count + len + 1 <= RD_FIFO_DEPTH, evaluated each cycle including pops that cycle. Then -> AR.
- AR: arvalid=1, holding araddr/arlen stable until arready, then -> R.
- R:
  - Every rvalid pushes {cnt==len, rdata} into the FIFO.
  - The beat with cnt==len -> IDLE.
  - Incoming m_axi_rlast is not used.
- m_axi_rready = !fifo_full in all states. The bridge gates arready on it.
- If rvalid arrives while the FIFO is full: drop the beat, set err_rd_ovf, still advance cnt. This is unreachable under legal operation.
- FIFO:
  - First-word latency: a beat pushed in cycle N gives rd_valid=1 in N+1.
  - Simultaneous push and pop at full or empty are both honoured.
  - Pointers wrap modulo RD_FIFO_DEPTH.
  - Drains normally in all states.
- One burst outstanding at a time. A write never overlaps a read.
- cmd_len=0 gives single-beat bursts: wlast and rd_last on the only beat.

Optional Feature:
Macro DDR_BM_PERF_EN.
- Defined: adds outputs perf_wr_beats[31:0], perf_rd_beats[31:0] and perf_stall[31:0].
  - perf_wr_beats counts W handshakes.
  - perf_rd_beats counts FIFO pushes.
  - perf_stall counts cycles in AR_WAIT, plus cycles in AW or AR with valid high and ready low.
  - All three wrap at 2^32 and clear on reset.
- Undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
- Write, cmd_addr=0x100, cmd_len=3, wready=1 always -> awaddr=0x100, awlen=3, 4 W beats in order, wlast only on 4th, wstrb=0xFFFFFFFF, cmd_ready=1 the cycle after the last beat.
- Read, cmd_addr=0x2000, cmd_len=15, FIFO empty, rd_ready=1 -> arlen=15, 16 rd beats match injected rdata order, rd_last only on 16th, busy falls after the 16th push.
- Credit stall: RD_FIFO_DEPTH=32, preload 20 unpopped beats, read cmd_len=15 -> arvalid stays 0 until the sink pops 4 beats, then arvalid=1 the next cycle.
- Illegal length: cmd_len=16 with MAX_LEN=16 -> err_len=1, awvalid=arvalid=0 throughout, cmd_ready remains 1.
- Alignment plus wready stalls: write cmd_addr=0x1F3, cmd_len=1, wready toggling -> awaddr=0x1E0, exactly 2 beats with data held stable while wready=0.
- Reset mid-burst: assert ui_clk_sync_rst during W beat 2 of 4 -> next cycle awvalid=wvalid=arvalid=0, rd_valid=0, busy=0, errors cleared.
